// File: rtl/com_pkg.sv
// Shared types and default constants for the COM fault supervisor.
package com_pkg;

    typedef enum logic [1:0] {
        RUN,
        TRIP,
        HOLD,
        WAIT_CLR
    } com_state_t;

    localparam int HOLD_CYC_DEF = 50000;
    localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/com_hold_timer.sv
// Minimum fault-hold timer: counts 0..HOLD_CYC-1 while run is high and
// pulses done on the terminal count.
module com_hold_timer
    import com_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic CLK_50M,
    input  logic clear,
    input  logic run,
    output logic done
);

    localparam int TMR_W = $clog2(HOLD_CYC + 1);
    localparam logic [TMR_W-1:0] LAST = TMR_W'(HOLD_CYC - 1);

    logic [TMR_W-1:0] count;

    assign done = run && (count == LAST);

    always_ff @(posedge CLK_50M) begin
        if (clear) begin
            count <= '0;
        end else if (run) begin
            if (done) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/com_fault_supervisor.sv
// Latches COM faults, drops gate drive, enforces a hold time and a DSP clear
// handshake. Optional saturating trip counter built when COM_TRIP_CNT_EN is defined.
module com_fault_supervisor
    import com_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             CLK_50M,
    input  logic             Rst,
    input  logic             COM1_IPF_D,
    input  logic             Enable,
    input  logic             Clr_Req,
    output logic             PWM_EN,
    output logic             Fault_Latch,
    output logic             Clr_Ack,
    output logic [CNT_W-1:0] Trip_Cnt
);

    com_state_t state;
    com_state_t next_state;
    logic       hold_clear;
    logic       hold_run;
    logic       hold_done;

    // Timer is held at zero outside HOLD so every trip starts a fresh hold window.
    assign hold_clear = Rst || (state != HOLD);
    assign hold_run   = (state == HOLD);

    com_hold_timer #(
        .HOLD_CYC(HOLD_CYC)
    ) u_hold_timer (
        .CLK_50M(CLK_50M),
        .clear  (hold_clear),
        .run    (hold_run),
        .done   (hold_done)
    );

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (COM1_IPF_D) begin
                    next_state = TRIP;
                end
            end
            TRIP: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (hold_done) begin
                    next_state = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (Clr_Req && !COM1_IPF_D) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Outputs are decoded from next_state so the fault removes drive one cycle after it is sampled.
    always_ff @(posedge CLK_50M) begin
        if (Rst) begin
            state       <= RUN;
            PWM_EN      <= 1'b0;
            Fault_Latch <= 1'b0;
            Clr_Ack     <= 1'b0;
        end else begin
            state       <= next_state;
            PWM_EN      <= (next_state == RUN) && Enable;
            Fault_Latch <= (next_state != RUN);
            Clr_Ack     <= (state == WAIT_CLR) && (next_state == RUN);
        end
    end

`ifdef COM_TRIP_CNT_EN
    logic [CNT_W-1:0] trip_cnt;

    always_ff @(posedge CLK_50M) begin
        if (Rst) begin
            trip_cnt <= '0;
        end else if ((state == TRIP) && (trip_cnt != {CNT_W{1'b1}})) begin
            trip_cnt <= trip_cnt + 1'b1;
        end
    end

    assign Trip_Cnt = trip_cnt;
`else
    assign Trip_Cnt = '0;
`endif

endmodule

// File: tb/tb_com_fault_supervisor.sv
// Self-checking bench for com_fault_supervisor using a timestamp-based reference model.
module tb_com_fault_supervisor;

    localparam int HOLD_CYC = 4;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             CLK_50M = 1'b0;
    logic             Rst;
    logic             COM1_IPF_D;
    logic             Enable;
    logic             Clr_Req;
    logic             PWM_EN;
    logic             Fault_Latch;
    logic             Clr_Ack;
    logic [CNT_W-1:0] Trip_Cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit m_latched   = 1'b0;
    bit m_pwm       = 1'b0;
    bit m_ack       = 1'b0;
    int m_cnt       = 0;
    int m_trip_edge = 0;

    logic [CNT_W-1:0] exp_cnt;

    com_fault_supervisor #(
        .HOLD_CYC(HOLD_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK_50M    (CLK_50M),
        .Rst        (Rst),
        .COM1_IPF_D (COM1_IPF_D),
        .Enable     (Enable),
        .Clr_Req    (Clr_Req),
        .PWM_EN     (PWM_EN),
        .Fault_Latch(Fault_Latch),
        .Clr_Ack    (Clr_Ack),
        .Trip_Cnt   (Trip_Cnt)
    );

    always #10 CLK_50M = ~CLK_50M;

    // Model tracks the edge at which a trip was taken; hold and clear windows follow from that timestamp.
    task automatic modelStep(input bit rst, input bit fault, input bit en, input bit clr);
        if (rst) begin
            m_latched = 1'b0;
            m_pwm     = 1'b0;
            m_ack     = 1'b0;
            m_cnt     = 0;
        end else if (!m_latched) begin
            m_ack = 1'b0;
            if (fault) begin
                m_latched   = 1'b1;
                m_trip_edge = cyc;
                m_pwm       = 1'b0;
            end else begin
                m_pwm = en;
            end
        end else begin
            m_ack = 1'b0;
            m_pwm = 1'b0;
`ifdef COM_TRIP_CNT_EN
            if (cyc == m_trip_edge + 1 && m_cnt < CNT_MAX) begin
                m_cnt = m_cnt + 1;
            end
`endif
            if (cyc >= m_trip_edge + HOLD_CYC + 2 && clr && !fault) begin
                m_latched = 1'b0;
                m_ack     = 1'b1;
                m_pwm     = en;
            end
        end
    endtask

    task automatic checkOutput();
        exp_cnt = CNT_W'(m_cnt);
        checks++;
        assert (PWM_EN === m_pwm) else begin
            failures++;
            $error("[TB] FAIL pwm_en cyc=%0d observed=%b expected=%b", cyc, PWM_EN, m_pwm);
        end
        checks++;
        assert (Fault_Latch === m_latched) else begin
            failures++;
            $error("[TB] FAIL fault_latch cyc=%0d observed=%b expected=%b", cyc, Fault_Latch, m_latched);
        end
        checks++;
        assert (Clr_Ack === m_ack) else begin
            failures++;
            $error("[TB] FAIL clr_ack cyc=%0d observed=%b expected=%b", cyc, Clr_Ack, m_ack);
        end
        checks++;
        assert (Trip_Cnt === exp_cnt) else begin
            failures++;
            $error("[TB] FAIL trip_cnt cyc=%0d observed=%0d expected=%0d", cyc, Trip_Cnt, exp_cnt);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit fault, input bit en, input bit clr);
        Rst        = rst;
        COM1_IPF_D = fault;
        Enable     = en;
        Clr_Req    = clr;
        @(posedge CLK_50M);
        cyc++;
        modelStep(rst, fault, en, clr);
        #1;
        checkOutput();
    endtask

    initial begin
        $display("[TB] start HOLD_CYC=%0d CNT_W=%0d", HOLD_CYC, CNT_W);

        // Reset, then enable with no fault.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

        // Single-cycle fault, wait out the hold, then a one-cycle clear.
        applyStimulus(0, 1, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

        // Fault coinciding with Enable rising, clear held high through HOLD.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0);

        // Fault still present while clearing: no ack until the fault drops.
        applyStimulus(0, 1, 1, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 0);

        // Back-to-back trips, re-faulting on the first RUN cycle after each clear.
        for (int t = 0; t < 300; t++) begin
            applyStimulus(0, 1, 1'($urandom_range(0, 1)), 0);
            for (int i = 0; i < 5; i++)
                applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            applyStimulus(0, 1'($urandom_range(0, 1)), 1, 0);
            applyStimulus(0, 0, 1'($urandom_range(0, 1)), 1);
        end
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0);

        // Reset asserted mid-HOLD with the timer at 2.
        applyStimulus(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/com_fault_supervisor.md
# com_fault_supervisor

Protection supervisor sitting directly downstream of the COM glitch filter in the CPLD. It consumes the debounced fault line (COM1_IPF_D), latches a fault, immediately removes the gate-drive enable, and enforces a minimum fault-hold time. After the hold time it requires an explicit clear handshake from the DSP before drive is re-enabled. An optional saturating trip counter is exposed for diagnostics.

## Interface
Parameters:
- HOLD_CYC, 50000: minimum number of cycles spent in HOLD after a trip (1 ms at 50 MHz); legal range ≥ 1.
- CNT_W, 8: width of the trip counter.

Ports:
- CLK_50M  in  1  system clock, 50 MHz. One clock; reset is synchronous and active-high.
- Rst  in  1  synchronous, active-high reset.
- COM1_IPF_D  in  1  filtered fault input; 1 = fault present.
- Enable  in  1  DSP run request; gates PWM_EN only, and has no effect on fault logic.
- Clr_Req  in  1  DSP fault-clear request; level-sampled every cycle.
- PWM_EN  out  1  gate-drive enable, registered.
- Fault_Latch  out  1  latched fault flag, registered.
- Clr_Ack  out  1  single-cycle clear acknowledge.
- Trip_Cnt  out  CNT_W  saturating trip count.

## Operation
- States: RUN, TRIP, HOLD, WAIT_CLR.
- RUN:
  - if COM1_IPF_D = 1, go to TRIP.
  - PWM_EN = Enable; Fault_Latch = 0.
- TRIP:
  - single-cycle state that always goes to HOLD.
  - increments Trip_Cnt, saturating at 2^CNT_W − 1 (no wrap).
  - clears the hold timer.
- HOLD:
  - hold timer counts 0 … HOLD_CYC−1; on the terminal count, go to WAIT_CLR.
  - Clr_Req is ignored and not remembered.
  - COM1_IPF_D activity is ignored (no re-trip, no timer restart).
- WAIT_CLR:
  - if Clr_Req = 1 and COM1_IPF_D = 0, go to RUN and pulse Clr_Ack.
  - if Clr_Req = 1 and COM1_IPF_D = 1, stay in WAIT_CLR with no ack.
- In TRIP, HOLD and WAIT_CLR: PWM_EN = 0 and Fault_Latch = 1.
- Clr_Req held high across several cycles produces exactly one Clr_Ack, because the state leaves WAIT_CLR.
- If Clr_Req is still high on the first RUN cycle, it has no effect.
- Enable toggling never changes state.
- Hold timer width: $clog2(HOLD_CYC+1) bits. The timer runs only in HOLD and is cleared in every other state.

## Timing
- Reset values: state = RUN, PWM_EN = 0, Fault_Latch = 0, Clr_Ack = 0, Trip_Cnt = 0, hold timer = 0.
- Reset mid-operation (any state, any timer value) forces the reset values on the next edge. Trip_Cnt is cleared by reset as well.
- First cycle after Rst is released: PWM_EN = Enable, provided COM1_IPF_D = 0.
- Fault sampled high at edge k while in RUN:
  - edge k+1: TRIP, PWM_EN = 0, Fault_Latch = 1.
  - edge k+2: HOLD, Trip_Cnt incremented.
  - edge k+2+HOLD_CYC: WAIT_CLR.
- Fault latency from COM1_IPF_D to PWM_EN low is exactly 1 cycle.
- Clr_Req accepted at edge m in WAIT_CLR:
  - edge m+1: RUN, Clr_Ack = 1, Fault_Latch = 0, PWM_EN = Enable.
  - edge m+2: Clr_Ack = 0.
- Simultaneous fault and Enable rising in RUN: the fault wins, so PWM_EN stays 0.
- Fault re-asserted on the first RUN cycle after a clear: normal trip on the next edge.

## Configuration
- COM_TRIP_CNT_EN defined: the Trip_Cnt register and its saturating increment are built.
- COM_TRIP_CNT_EN undefined:
  - Trip_Cnt is tied to 0 and no counter register exists.
  - All other behaviour is identical.

## Structure
- Package com_pkg:
  - state enum (RUN, TRIP, HOLD, WAIT_CLR).
  - default constants HOLD_CYC_DEF = 50000 and CNT_W_DEF = 8.
- Sub-module com_hold_timer:
  - inputs: clear and run enable; output: terminal-count pulse; parameterised by HOLD_CYC.
  - instantiated once.
- Top level: state register, output registers, counter.

## Test plan
- Reset then Enable = 1 with fault low:
  - PWM_EN = 1 one cycle after reset release.
  - all other outputs 0.
- Single fault cycle at edge k, with HOLD_CYC = 4 on the bench:
  - PWM_EN falls at k+1.
  - Trip_Cnt = 1 at k+2.
  - WAIT_CLR at k+6.
  - Clr_Req accepted there gives Clr_Ack high for exactly one cycle at k+7.
- Clr_Req held high throughout HOLD, fault already low:
  - no ack during HOLD.
  - ack exactly on the first WAIT_CLR cycle +1.
  - only one ack pulse in total.
- Fault still high in WAIT_CLR with Clr_Req = 1 for 10 cycles:
  - no ack and Fault_Latch stays 1.
  - drop the fault; ack follows 1 cycle later.
- 300 back-to-back trips with CNT_W = 8: Trip_Cnt saturates at 255.
  - build without COM_TRIP_CNT_EN: Trip_Cnt stays 0.
- Rst asserted mid-HOLD (timer = 2): all outputs return to their reset values on the next edge.
